// File: rtl/llc_dma_initiator.sv
// Burst DMA initiator: splits a line-granular read/write command into per-line LLC
// requests, bounds requests in flight, and forwards read data to the line stream.
module llc_dma_initiator #(
  parameter int ADDR_W  = 28,
  parameter int LINE_W  = 128,
  parameter int LEN_W   = 16,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [LINE_W-1:0] wdata,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [LINE_W-1:0] req_line,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic [LINE_W-1:0] rsp_line,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [LINE_W-1:0] rdata,
  output logic              busy,
  output logic              done
);

  localparam int OUT_W = $clog2(MAX_OUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   issued;
  logic [LEN_W-1:0]   received;
  logic [OUT_W-1:0]   outstanding;
  logic [OUT_W-1:0]   out_nxt;
  logic [LEN_W-1:0]   issued_inc;
  logic [LEN_W-1:0]   received_inc;
  logic               cmd_fire;
  logic               req_fire;
  logic               rsp_fire;
  logic               active;
  logic               last_req;
  logic               last_rsp;

  assign issued_inc   = issued + LEN_W'(1);
  assign received_inc = received + LEN_W'(1);
  assign cmd_fire     = cmd_valid & cmd_ready;
  assign req_fire     = req_valid & req_ready;
  assign rsp_fire     = rsp_valid & rsp_ready;
  assign last_req     = req_fire & (issued_inc == len_q);
  assign last_rsp     = rsp_fire & (received_inc == len_q);

  always_comb begin
    state_nxt   = state;
    active      = (state == ISSUE) || (state == DRAIN);
    cmd_ready   = (state == IDLE);
    busy        = active;
    done        = (state == DONE);
    req_valid   = (state == ISSUE) && (issued < len_q) &&
                  (outstanding < OUT_W'(MAX_OUT)) && (!wr_q || wdata_valid);
    req_write   = wr_q;
    req_addr    = addr_q;
    req_line    = wr_q ? wdata : '0;
    wdata_ready = wr_q & req_valid & req_ready;
    // Read responses pass straight through; write acks are always accepted.
    rsp_ready   = active && (wr_q || rdata_ready);
    rdata_valid = active && !wr_q && rsp_valid;
    rdata       = (active && !wr_q) ? rsp_line : '0;

    case (state)
      IDLE: begin
        if (cmd_valid) state_nxt = (cmd_len == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        if (last_rsp)      state_nxt = DONE;
        else if (last_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_rsp) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // A simultaneous request and response leaves the in-flight count unchanged.
  always_comb begin
    out_nxt = outstanding;
    case ({req_fire, rsp_fire})
      2'b10:   out_nxt = outstanding + OUT_W'(1);
      2'b01:   out_nxt = (outstanding == '0) ? outstanding : outstanding - OUT_W'(1);
      default: out_nxt = outstanding;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      issued      <= '0;
      received    <= '0;
      outstanding <= '0;
    end else begin
      state <= state_nxt;
      if (cmd_fire) begin
        wr_q        <= cmd_write;
        addr_q      <= cmd_addr;
        len_q       <= cmd_len;
        issued      <= '0;
        received    <= '0;
        outstanding <= '0;
      end else begin
        if (req_fire) begin
          addr_q <= addr_q + ADDR_W'(1);
          issued <= issued_inc;
        end
        if (rsp_fire) received <= received_inc;
        outstanding <= out_nxt;
      end
    end
  end

endmodule

// File: tb/tb_llc_dma_initiator.sv
// Directed bench for llc_dma_initiator: read/write bursts, in-flight limit,
// address wrap, zero-length command, read backpressure and mid-burst reset.
module tb_llc_dma_initiator;

  localparam int ADDR_W  = 28;
  localparam int LINE_W  = 128;
  localparam int LEN_W   = 16;
  localparam int MAX_OUT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              wdata_valid = 1'b0;
  logic              wdata_ready;
  logic [LINE_W-1:0] wdata = '0;
  logic              req_valid;
  logic              req_ready = 1'b0;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_line;
  logic              rsp_valid = 1'b0;
  logic              rsp_ready;
  logic [LINE_W-1:0] rsp_line = '0;
  logic              rdata_valid;
  logic              rdata_ready = 1'b0;
  logic [LINE_W-1:0] rdata;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_fail   = 0;
  int rfires;
  int sfires;
  logic got_done;

  always #5 clk = ~clk;

  llc_dma_initiator #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .LEN_W(LEN_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_line(req_line),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_line(rsp_line),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  // Presents a command for one cycle; returns at the first cycle after the fire.
  task automatic cmd(input logic wr, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    nx();
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    nx();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    // reset state
    nx(); nx(); nx();
    rst = 1'b1; rsp_valid = 1'b1; rsp_line = 'h99;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("idle_rsp_ready", rsp_ready, 0);
    chk("idle_rdata_valid", rdata_valid, 0);
    nx();
    rsp_valid = 1'b0;

    // read burst addr 0x100 len 3, responses two cycles after each request
    req_ready = 1'b1; rdata_ready = 1'b1;
    cmd(1'b0, 'h100, 3);
    #1;
    chk("rd_busy", busy, 1);
    chk("rd_req_valid", req_valid, 1);
    chk("rd_write", req_write, 0);
    chk("rd_addr0", req_addr, 'h100);
    chk("rd_line0", req_line, 0);
    nx(); #1;
    chk("rd_addr1", req_addr, 'h101);
    nx(); rsp_valid = 1'b1; rsp_line = 'hA0; #1;
    chk("rd_addr2", req_addr, 'h102);
    chk("rd_rsp_ready", rsp_ready, 1);
    chk("rd_dv0", rdata_valid, 1);
    chk("rd_d0", rdata, 'hA0);
    nx(); rsp_line = 'hA1; #1;
    chk("rd_drain_req_valid", req_valid, 0);
    chk("rd_d1", rdata, 'hA1);
    nx(); rsp_line = 'hA2; #1;
    chk("rd_d2", rdata, 'hA2);
    chk("rd_busy_drain", busy, 1);
    chk("rd_no_early_done", done, 0);
    nx(); rsp_valid = 1'b0; #1;
    chk("rd_done", done, 1);
    chk("rd_done_busy", busy, 0);
    chk("rd_done_cmd_ready", cmd_ready, 0);
    nx(); #1;
    chk("rd_done_pulse", done, 0);
    chk("rd_back_idle", cmd_ready, 1);

    // write len 6 with responses withheld: stalls at MAX_OUT in flight
    wdata_valid = 1'b1; wdata = 'hBEEF; req_ready = 1'b1;
    cmd(1'b1, 'h2000, 6);
    #1;
    chk("wr_req_write", req_write, 1);
    chk("wr_req_line", req_line, 'hBEEF);
    chk("wr_wdata_ready", wdata_ready, 1);
    chk("wr_rsp_ready", rsp_ready, 1);
    rfires = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin nx(); #1; end
      if (req_valid && req_ready) rfires++;
    end
    chk("wr_fires_limited", rfires, 4);
    chk("wr_stall_req_valid", req_valid, 0);
    chk("wr_stall_wdata_ready", wdata_ready, 0);
    nx(); rsp_valid = 1'b1; #1;
    chk("wr_release_req_valid", req_valid, 0);
    nx(); rsp_valid = 1'b0; #1;
    chk("wr_fifth_req_valid", req_valid, 1);
    chk("wr_fifth_addr", req_addr, 'h2004);
    rfires = 5; sfires = 1; got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      nx(); rsp_valid = 1'b1; #1;
      if (done) got_done = 1'b1;
      else begin
        if (req_valid && req_ready) rfires++;
        if (rsp_valid && rsp_ready) sfires++;
      end
    end
    chk("wr_done_seen", got_done, 1);
    chk("wr_done_rsp_ready", rsp_ready, 0);
    chk("wr_total_req", rfires, 6);
    chk("wr_total_rsp", sfires, 6);
    rsp_valid = 1'b0;

    // write with address wrap at 2^ADDR_W
    wdata = 'h1111; req_ready = 1'b0;
    cmd(1'b1, 28'hFFFFFFF, 2);
    #1;
    chk("wrap_req_valid", req_valid, 1);
    chk("wrap_wready_no_fire", wdata_ready, 0);
    chk("wrap_addr_held", req_addr, 'hFFFFFFF);
    nx(); req_ready = 1'b1; #1;
    chk("wrap_wready_fire0", wdata_ready, 1);
    chk("wrap_addr0", req_addr, 'hFFFFFFF);
    chk("wrap_line0", req_line, 'h1111);
    nx(); wdata = 'h2222; #1;
    chk("wrap_addr1", req_addr, 0);
    chk("wrap_line1", req_line, 'h2222);
    chk("wrap_wready_fire1", wdata_ready, 1);
    nx(); rsp_valid = 1'b1; #1;
    chk("wrap_wready_drain", wdata_ready, 0);
    chk("wrap_req_valid_drain", req_valid, 0);
    nx(); #1;
    chk("wrap_no_early_done", done, 0);
    nx(); rsp_valid = 1'b0; #1;
    chk("wrap_done", done, 1);

    // zero-length command
    wdata_valid = 1'b0;
    cmd(1'b0, 'h55, 0);
    #1;
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_req_valid", req_valid, 0);
    chk("len0_cmd_ready", cmd_ready, 0);
    nx(); #1;
    chk("len0_done_pulse", done, 0);
    chk("len0_idle", cmd_ready, 1);

    // read with rdata backpressure
    rdata_ready = 1'b0; req_ready = 1'b1;
    cmd(1'b0, 'h40, 4);
    #1;
    chk("bp_addr0", req_addr, 'h40);
    nx(); nx(); nx(); #1;
    chk("bp_addr3", req_addr, 'h43);
    nx(); rsp_valid = 1'b1; rsp_line = 'hC0; #1;
    chk("bp_req_valid_full", req_valid, 0);
    chk("bp_rsp_ready", rsp_ready, 0);
    chk("bp_rdata_valid", rdata_valid, 1);
    chk("bp_rdata", rdata, 'hC0);
    nx(); #1;
    chk("bp_rsp_ready_held", rsp_ready, 0);
    chk("bp_still_full", req_valid, 0);
    nx(); rdata_ready = 1'b1; #1;
    chk("bp_release_rsp_ready", rsp_ready, 1);
    chk("bp_d0", rdata, 'hC0);
    nx(); rsp_line = 'hC1; #1;
    chk("bp_d1", rdata, 'hC1);
    nx(); rsp_line = 'hC2; #1;
    chk("bp_d2", rdata, 'hC2);
    nx(); rsp_line = 'hC3; #1;
    chk("bp_d3", rdata, 'hC3);
    chk("bp_no_early_done", done, 0);
    nx(); rsp_valid = 1'b0; #1;
    chk("bp_done", done, 1);

    // reset in the middle of a read burst
    cmd(1'b0, 'h80, 4);
    nx();
    nx(); rst = 1'b0; #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req_valid", req_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_addr", req_addr, 0);
    nx(); rst = 1'b1; rsp_valid = 1'b1; rsp_line = 'hDD; #1;
    chk("late_rsp_ready", rsp_ready, 0);
    chk("late_rdata_valid", rdata_valid, 0);
    chk("late_cmd_ready", cmd_ready, 1);
    nx(); #1;
    chk("late_no_done", done, 0);
    rsp_valid = 1'b0;
    cmd(1'b0, 'h7, 1);
    #1;
    chk("post_rst_req_valid", req_valid, 1);
    chk("post_rst_addr", req_addr, 'h7);
    nx(); rsp_valid = 1'b1; rsp_line = 'hE7; #1;
    chk("post_rst_rdata_valid", rdata_valid, 1);
    chk("post_rst_rdata", rdata, 'hE7);
    nx(); rsp_valid = 1'b0; #1;
    chk("post_rst_done", done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
